// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: streams a program into imem while holding the core in reset,
// then enables the core for a bounded (or host-halted) number of cycles.
module imem_boot_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic              halt_req,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  elapsed,
    output logic [2:0]        state
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RELEASE = 3'd2, RUN = 3'd3, HALT = 3'd4} state_t;
    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;
    state_t              r_state, w_next;
    logic [ADDR_W:0]     r_nwords, r_idx, w_nclamp;
    logic [CNT_W-1:0]    r_budget, r_elapsed;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we, r_done;
    logic                w_launch, w_accept, w_last, w_term;
    assign w_nclamp = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign w_launch = (r_state == IDLE || r_state == HALT) && start;
    assign w_accept = (r_state == LOAD) && s_valid;
    assign w_last   = r_idx == r_nwords - (ADDR_W+1)'(1);
    // halt_req and terminal count share one exit so they can only yield one done pulse
    assign w_term   = halt_req || (r_budget != '0 && r_elapsed == r_budget - CNT_W'(1));
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, HALT: w_next = w_launch ? ((w_nclamp == '0) ? RELEASE : LOAD) : r_state;
            LOAD:       w_next = (w_accept && w_last) ? RELEASE : LOAD;
            RELEASE:    w_next = RUN;
            RUN:        w_next = w_term ? HALT : RUN;
            default:    w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_nwords  <= '0;
            r_idx     <= '0;
            r_budget  <= '0;
            r_elapsed <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_we    <= w_accept;
            r_done  <= (r_state == RUN) && w_term;
            if (w_accept) begin
                r_addr  <= r_idx[ADDR_W-1:0];
                r_wdata <= s_data;
                r_idx   <= r_idx + (ADDR_W+1)'(1);
            end
            if (w_launch) begin
                r_nwords  <= w_nclamp;
                r_budget  <= run_cycles;
                r_idx     <= '0;
                r_elapsed <= '0;
            end else if (r_state == RUN && !w_term && r_elapsed != '1) begin
                r_elapsed <= r_elapsed + CNT_W'(1);
            end
        end
    end
    assign s_ready    = r_state == LOAD;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_state == IDLE || r_state == LOAD || r_state == RELEASE;
    assign cpu_run    = r_state == RUN;
    assign busy       = r_state == LOAD || r_state == RELEASE || r_state == RUN;
    assign done       = r_done;
    assign elapsed    = r_elapsed;
    assign state      = r_state;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: randomized load/run scenarios checked against a
// cycle-level behavioural model of the boot sequence.
module tb_imem_boot_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int CW = 16;
    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, halt_req = 1'b0, s_valid = 1'b0;
    logic [AW:0]   num_words = '0;
    logic [CW-1:0] run_cycles = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_ready, imem_we, cpu_hold, cpu_run, busy, done;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [CW-1:0] elapsed;
    logic [2:0]    state;
    int            checks = 0, failures = 0;
    logic [DW-1:0] prog[$];

    always #5 clk = ~clk;

    imem_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .num_words(num_words), .run_cycles(run_cycles),
        .halt_req(halt_req), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .cpu_run(cpu_run), .busy(busy), .done(done), .elapsed(elapsed), .state(state)
    );

    task automatic test_reset;
        logic [3+6+AW+DW+CW-1:0] got;
        reset = 1'b0;
        #1;
        got = {state, s_ready, cpu_hold, cpu_run, busy, done, imem_we, imem_addr, imem_wdata, elapsed};
        checks++;
        if (got !== {3'd0, 6'b010000, {(AW+DW+CW){1'b0}}}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", got, {3'd0, 6'b010000, {(AW+DW+CW){1'b0}}});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_idle_ignore;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({state, s_ready, cpu_hold, cpu_run, imem_we} !== {3'd0, 4'b0100}) begin
                failures++;
                $display("FAIL idle_quiet cyc=%0d got=%b exp=%b", i, {state, s_ready, cpu_hold, cpu_run, imem_we}, {3'd0, 4'b0100});
            end
            halt_req = 1'($urandom % 2);
            s_valid  = 1'($urandom % 2);
            s_data   = $urandom;
        end
        halt_req = 1'b0;
        s_valid  = 1'b0;
    endtask

    // ph follows the spec's phases: 0 idle, 1 load, 2 release, 3 run, 4 halt
    task automatic run_scn(input string nm, input int nw, input int rc, input int hreq_at, input int vmode, input bit noise);
        int nc, sent, runcnt, ph, exp_runs, cyc, dones;
        bit exp_we, exp_done, tog;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] words[$];
        logic [8:0] exp_v, got_v;
        nc = (nw > (1 << AW)) ? (1 << AW) : nw;
        for (int i = 0; i < nc; i++) words.push_back(i < prog.size() ? prog[i] : $urandom);
        exp_runs = (hreq_at != 0 && (rc == 0 || hreq_at < rc)) ? hreq_at : rc;
        @(negedge clk);
        start = 1'b1;
        num_words = nw[AW:0];
        run_cycles = rc[CW-1:0];
        halt_req = 1'b0;
        s_valid = 1'b0;
        ph = (nc == 0) ? 2 : 1;
        sent = 0; runcnt = 0; cyc = 0; dones = 0;
        exp_we = 1'b0; exp_done = 1'b0; tog = 1'b1;
        exp_addr = '0; exp_data = '0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (ph == 3) runcnt++;
            exp_v = {ph[2:0], ph == 1, ph < 3, ph == 3, ph >= 1 && ph <= 3, exp_done, exp_we};
            got_v = {state, s_ready, cpu_hold, cpu_run, busy, done, imem_we};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL %s ctl cyc=%0d got=%b exp=%b", nm, cyc, got_v, exp_v);
            end
            if (exp_we) begin
                checks++;
                if ({imem_addr, imem_wdata} !== {exp_addr, exp_data}) begin
                    failures++;
                    $display("FAIL %s write cyc=%0d got=%h/%h exp=%h/%h", nm, cyc, imem_addr, imem_wdata, exp_addr, exp_data);
                end
            end
            if (ph >= 3) begin
                checks++;
                if (elapsed !== CW'(runcnt - 1)) begin
                    failures++;
                    $display("FAIL %s elapsed cyc=%0d got=%0d exp=%0d", nm, cyc, elapsed, runcnt - 1);
                end
            end
            if (done === 1'b1) dones++;
            if (ph == 4 && !exp_done) break;
            if (cyc > 2000) begin
                checks++;
                failures++;
                $display("FAIL %s timeout got=no_halt exp=halt", nm);
                break;
            end
            halt_req = noise ? 1'($urandom % 2) : 1'b0;
            start    = noise ? 1'($urandom % 2) : 1'b0;
            s_valid  = noise ? 1'($urandom % 2) : 1'b0;
            s_data   = $urandom;
            exp_we   = 1'b0;
            exp_done = 1'b0;
            case (ph)
                1: begin
                    s_valid = (vmode < 0) ? tog : ($urandom % 100 < vmode);
                    tog = !tog;
                    if (s_valid) begin
                        s_data = words[sent];
                        exp_we = 1'b1;
                        exp_addr = sent[AW-1:0];
                        exp_data = words[sent];
                        sent++;
                        if (sent == nc) ph = 2;
                    end
                end
                2: ph = 3;
                3: begin
                    halt_req = hreq_at != 0 && runcnt == hreq_at;
                    if (halt_req || (rc != 0 && runcnt == rc)) begin
                        ph = 4;
                        exp_done = 1'b1;
                    end
                end
                default: start = 1'b0;
            endcase
        end
        halt_req = 1'b0;
        s_valid = 1'b0;
        start = 1'b0;
        checks++;
        if (runcnt != exp_runs) begin
            failures++;
            $display("FAIL %s run_cycles got=%0d exp=%0d", nm, runcnt, exp_runs);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL %s done_pulses got=%0d exp=1", nm, dones);
        end
        checks++;
        if (sent != nc) begin
            failures++;
            $display("FAIL %s words_loaded got=%0d exp=%0d", nm, sent, nc);
        end
    endtask

    task automatic test_reset_mid_load;
        logic [3+6+AW+DW+CW-1:0] got;
        @(negedge clk);
        start = 1'b1; num_words = 5; run_cycles = 3;
        @(negedge clk);
        start = 1'b0; s_valid = 1'b1; s_data = 32'hdead_beef;
        @(negedge clk);
        s_data = 32'hcafe_f00d;
        @(negedge clk);
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        got = {state, s_ready, cpu_hold, cpu_run, busy, done, imem_we, imem_addr, imem_wdata, elapsed};
        checks++;
        if (got !== {3'd0, 6'b010000, {(AW+DW+CW){1'b0}}}) begin
            failures++;
            $display("FAIL mid_load_reset got=%h exp=%h", got, {3'd0, 6'b010000, {(AW+DW+CW){1'b0}}});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int rnw, rrc;
        test_reset;
        test_idle_ignore;
        prog = '{32'h0010_0093, 32'h0010_0113, 32'h0020_81B3};
        run_scn("basic", 3, 10, 0, 100, 1'b0);
        run_scn("bubbles", 3, 10, 0, -1, 1'b0);
        prog.delete();
        run_scn("zero_words", 0, 4, 0, 100, 1'b1);
        run_scn("halt_unbounded", 4, 0, 7, 50, 1'b1);
        run_scn("halt_coincide", 2, 5, 5, 100, 1'b0);
        rnw = $urandom_range(1, 20);
        rrc = $urandom_range(1, 30);
        run_scn("random", rnw, rrc, 0, 60, 1'b1);
        test_reset_mid_load;
        run_scn("reload", 3, 2, 0, 100, 1'b0);
        run_scn("clamp", 300, 3, 0, 100, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
